vdp_port_ctrl: RTL and testbench
================================

// Module: vdp_port_ctrl
// PURPOSE
//  CPU-side sequencer for the VDP I/O ports $BE (data) and $BF (control/status).
//  - Implements the two-byte control latch, the 14-bit address/code register, the read-ahead buffer and auto-increment.
//  - Arbitrates CPU VRAM accesses into the renderer's free slots through a req/ack handshake.
//  - Issues CRAM writes and VDP register writes.
//  - Sits between the ebus I/O decode (already synchronised strobes) and the VDP register file, VRAM and CRAM.
// PARAMETERS
//  VRAM_AW   14  VRAM address width; the address counter wraps at 2**VRAM_AW
//  NUM_REGS  11  number of VDP registers; register writes with idx >= NUM_REGS are dropped
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  io_wr         in   1   one-cycle port write strobe
//  io_rd         in   1   one-cycle port read strobe
//  io_sel_ctrl   in   1   0=$BE data port, 1=$BF control port; valid with a strobe
//  io_wrdata     in   8   write data
//  io_rddata     out  8   read data; valid from the cycle after io_rd until the next io_rd
//  stat_in       in   8   status byte from the VDP (frame/line int, overflow, collision)
//  stat_rd_ack   out  1   one-cycle pulse on a control-port read; VDP clears its flags
//  reg_wren      out  1   one-cycle register write pulse
//  reg_idx       out  4   register index
//  reg_data      out  8   register data
//  vram_req      out  1   VRAM access request; held until acknowledged
//  vram_we       out  1   1=write, 0=read; stable while vram_req
//  vram_addr     out  14  VRAM address; stable while vram_req
//  vram_wrdata   out  8   VRAM write data
//  vram_ack      in   1   grant; read data is valid in the same cycle
//  vram_rddata   in   8   VRAM read data
//  cram_wren     out  1   one-cycle CRAM write pulse
//  cram_addr     out  5   palette entry index
//  cram_wrdata   out  16  palette data; bits [15:8] are 0 unless VDP_GG_CRAM_EN
//  overrun       out  1   sticky: a data access was dropped; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0. addr=0, code=0, latch=0, buffer=0, FSM=IDLE, pending slot empty.
//  Control write, latch=0:
//    - addr[7:0] <= data immediately; latch <= 1.
//  Control write, latch=1:
//    - addr[13:8] <= data[5:0]; code <= data[7:6]; latch <= 0.
//    - code 0: queue a read-ahead (VRAM read at addr into buffer, then addr++).
//    - code 2: reg_wren pulses the next cycle with idx=data[3:0] and data=addr[7:0].
//  Control read:
//    - io_rddata <= stat_in; stat_rd_ack pulses; latch <= 0.
//  Data write:
//    - latch <= 0; buffer <= data.
//    - code 3: cram_wren pulses the next cycle at addr[4:0], no VRAM access.
//    - otherwise: queue a VRAM write at addr.
//    - addr++ in all cases.
//  Data read:
//    - latch <= 0; io_rddata <= buffer; then queue a read-ahead at addr; addr++.
//  addr++ wraps 3FFF -> 0000. It is applied when the access is queued, so a queued op carries its own address.
//  FSM states:
//    - IDLE -> REQ when a queued op exists.
//    - REQ: vram_req=1 until vram_ack. On ack: read writes buffer<=vram_rddata; drop vram_req the same edge.
//    - REQ -> IDLE on ack; REQ -> REQ directly if the pending slot is occupied.
//    - No minimum latency. Starvation is the renderer's responsibility.
//  Pending slot: one entry beyond the active op.
//    - A data access arriving while both are occupied is dropped and sets overrun.
//    - Control/status side effects are never dropped.
//  A data read while a read-ahead is outstanding returns the stale buffer; this is hardware-accurate.
//  io_wr and io_rd in the same cycle: io_wr wins and io_rd is ignored.
//  Reset mid-request: vram_req drops asynchronously and the op is lost.
// CONFIGURATION
//  VDP_GG_CRAM_EN defined (Game Gear palette):
//    - CRAM is addressed by addr[5:0].
//    - An even-byte write is held in a latch with no pulse.
//    - An odd-byte write pulses cram_wren with cram_addr=addr[5:1] and cram_wrdata={4'b0, odd[3:0], even}.
//  VDP_GG_CRAM_EN undefined:
//    - cram_addr=addr[4:0], cram_wrdata={8'h00, data[5:0] zero-extended}.
//    - One pulse per write; the even latch does not exist.
// TESTING
//  1. Ctrl 00,C0; data 01..07 -> 7 cram_wren pulses, addr 0..6, data 01..07; no vram_req.
//  2. Ctrl 20,81 -> single reg_wren, idx=1, data=20; addr[7:0]=20.
//  3. Ctrl 00,46; data A5,A6 (ack 3 cycles after each req) -> VRAM writes 0600=A5, 0601=A6; addr ends at 0602.
//  4. After test 3, ctrl 00,06 -> read-ahead at 0600. Data reads -> io_rddata A5, A6; last read-ahead at 0602.
//  5. Ctrl 00 only, then a data read -> latch cleared. Next ctrl 34,7F -> addr 3F34, code 1.
//     - Data write at 3FFF -> next write lands at 0000.
//  6. Hold vram_ack=0 for 40 cycles; issue 3 data writes -> first two complete in order after ack, third dropped, overrun=1.

Source files
------------

// File: rtl/vdp_port_ctrl.sv
// vdp_port_ctrl: CPU-side sequencer for VDP ports $BE (data) and $BF (control/status).
// Handles the two-byte control latch, the address/code register, the read-ahead buffer
// and VRAM/CRAM/register writes. VRAM accesses go through one active op plus one
// pending slot.
// Optional feature: define VDP_GG_CRAM_EN for the Game Gear 12-bit palette (even/odd byte pairing).
module vdp_port_ctrl #(
    parameter int unsigned VRAM_AW  = 14,
    parameter int unsigned NUM_REGS = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               io_wr,
    input  logic               io_rd,
    input  logic               io_sel_ctrl,
    input  logic [7:0]         io_wrdata,
    output logic [7:0]         io_rddata,
    input  logic [7:0]         stat_in,
    output logic               stat_rd_ack,
    output logic               reg_wren,
    output logic [3:0]         reg_idx,
    output logic [7:0]         reg_data,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wrdata,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rddata,
    output logic               cram_wren,
    output logic [4:0]         cram_addr,
    output logic [15:0]        cram_wrdata,
    output logic               overrun
);

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [VRAM_AW-1:0] addr_q;
    logic [1:0]         code_q;
    logic               latch_q;
    logic [7:0]         buffer_q;
    logic               pend_valid_q;
    logic               pend_we_q;
    logic [VRAM_AW-1:0] pend_addr_q;
    logic [7:0]         pend_data_q;
`ifdef VDP_GG_CRAM_EN
    logic [7:0]         gg_even_q;
`endif

    logic               wr_ctrl, wr_data, rd_ctrl, rd_data, ack_c;
    logic [VRAM_AW-1:0] hi_addr_c;
    logic               push_c, push_we_c;
    logic [VRAM_AW-1:0] push_addr_c;
    logic [7:0]         push_data_c;
    logic               load_act_c, act_from_pend_c, load_pend_c, clr_pend_c, drop_c;

    // Strobe decode; a write strobe masks a simultaneous read strobe
    assign wr_ctrl   = io_wr & io_sel_ctrl;
    assign wr_data   = io_wr & ~io_sel_ctrl;
    assign rd_ctrl   = io_rd & ~io_wr & io_sel_ctrl;
    assign rd_data   = io_rd & ~io_wr & ~io_sel_ctrl;
    assign ack_c     = (state_q == REQ) & vram_ack;
    assign hi_addr_c = {io_wrdata[VRAM_AW-9:0], addr_q[7:0]};

    // Decode the VRAM op (if any) the current port access wants to queue
    always_comb begin
        push_c      = 1'b0;
        push_we_c   = 1'b0;
        push_addr_c = addr_q;
        push_data_c = io_wrdata;
        if (wr_ctrl && latch_q && io_wrdata[7:6] == 2'd0) begin
            push_c      = 1'b1;
            push_addr_c = hi_addr_c;
        end else if (wr_data && code_q != 2'd3) begin
            push_c    = 1'b1;
            push_we_c = 1'b1;
        end else if (rd_data) begin
            push_c = 1'b1;
        end
    end

    // Route a queued op into the active slot, the pending slot, or drop it
    always_comb begin
        load_act_c      = 1'b0;
        act_from_pend_c = 1'b0;
        load_pend_c     = 1'b0;
        clr_pend_c      = 1'b0;
        drop_c          = 1'b0;
        if (state_q == IDLE) begin
            load_act_c = push_c;
        end else if (ack_c) begin
            if (pend_valid_q) begin
                act_from_pend_c = 1'b1;
                load_pend_c     = push_c;
                clr_pend_c      = ~push_c;
            end else begin
                load_act_c = push_c;
            end
        end else if (push_c) begin
            drop_c      = pend_valid_q;
            load_pend_c = ~pend_valid_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: stay in REQ while any op remains after the ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (push_c) state_d = REQ;
            REQ:  if (ack_c && !pend_valid_q && !push_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output: request is exactly the REQ state bit
    always_comb begin
        vram_req = (state_q == REQ);
    end

    // Port-side registers, op slots, buffer and output pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            code_q       <= 2'd0;
            latch_q      <= 1'b0;
            buffer_q     <= 8'h00;
            pend_valid_q <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= 8'h00;
            io_rddata    <= 8'h00;
            stat_rd_ack  <= 1'b0;
            reg_wren     <= 1'b0;
            reg_idx      <= 4'h0;
            reg_data     <= 8'h00;
            vram_we      <= 1'b0;
            vram_addr    <= '0;
            vram_wrdata  <= 8'h00;
            cram_wren    <= 1'b0;
            cram_addr    <= 5'h00;
            cram_wrdata  <= 16'h0000;
            overrun      <= 1'b0;
`ifdef VDP_GG_CRAM_EN
            gg_even_q    <= 8'h00;
`endif
        end else begin
            reg_wren    <= 1'b0;
            cram_wren   <= 1'b0;
            stat_rd_ack <= 1'b0;
            if (drop_c) overrun <= 1'b1;

            if (load_act_c) begin
                vram_we     <= push_we_c;
                vram_addr   <= push_addr_c;
                vram_wrdata <= push_data_c;
            end else if (act_from_pend_c) begin
                vram_we     <= pend_we_q;
                vram_addr   <= pend_addr_q;
                vram_wrdata <= pend_data_q;
            end

            if (load_pend_c) begin
                pend_valid_q <= 1'b1;
                pend_we_q    <= push_we_c;
                pend_addr_q  <= push_addr_c;
                pend_data_q  <= push_data_c;
            end else if (clr_pend_c) begin
                pend_valid_q <= 1'b0;
            end

            if (ack_c && !vram_we) buffer_q <= vram_rddata;

            if (wr_ctrl) begin
                if (!latch_q) begin
                    addr_q[7:0] <= io_wrdata;
                    latch_q     <= 1'b1;
                end else begin
                    code_q  <= io_wrdata[7:6];
                    latch_q <= 1'b0;
                    if (io_wrdata[7:6] == 2'd0) addr_q <= hi_addr_c + VRAM_AW'(1);
                    else                        addr_q <= hi_addr_c;
                    if (io_wrdata[7:6] == 2'd2 && 32'(io_wrdata[3:0]) < NUM_REGS) begin
                        reg_wren <= 1'b1;
                        reg_idx  <= io_wrdata[3:0];
                        reg_data <= addr_q[7:0];
                    end
                end
            end else if (wr_data) begin
                latch_q  <= 1'b0;
                buffer_q <= io_wrdata;
                addr_q   <= addr_q + VRAM_AW'(1);
                if (code_q == 2'd3) begin
`ifdef VDP_GG_CRAM_EN
                    if (!addr_q[0]) begin
                        gg_even_q <= io_wrdata;
                    end else begin
                        cram_wren   <= 1'b1;
                        cram_addr   <= addr_q[5:1];
                        cram_wrdata <= {4'h0, io_wrdata[3:0], gg_even_q};
                    end
`else
                    cram_wren   <= 1'b1;
                    cram_addr   <= addr_q[4:0];
                    cram_wrdata <= {8'h00, 2'b00, io_wrdata[5:0]};
`endif
                end
            end else if (rd_ctrl) begin
                latch_q     <= 1'b0;
                io_rddata   <= stat_in;
                stat_rd_ack <= 1'b1;
            end else if (rd_data) begin
                latch_q   <= 1'b0;
                io_rddata <= buffer_q;
                addr_q    <= addr_q + VRAM_AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Self-checking bench for vdp_port_ctrl (default palette build).
module tb_vdp_port_ctrl;

    logic        clk = 1'b0, reset = 1'b1;
    logic        io_wr = 1'b0, io_rd = 1'b0, io_sel_ctrl = 1'b0;
    logic [7:0]  io_wrdata = 8'h00, io_rddata;
    logic [7:0]  stat_in = 8'hA3;
    logic        stat_rd_ack, reg_wren;
    logic [3:0]  reg_idx;
    logic [7:0]  reg_data;
    logic        vram_req, vram_we, vram_ack = 1'b0;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wrdata, vram_rddata;
    logic        cram_wren;
    logic [4:0]  cram_addr;
    logic [15:0] cram_wrdata;
    logic        overrun;

    vdp_port_ctrl dut (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .io_sel_ctrl(io_sel_ctrl),
        .io_wrdata(io_wrdata), .io_rddata(io_rddata), .stat_in(stat_in), .stat_rd_ack(stat_rd_ack),
        .reg_wren(reg_wren), .reg_idx(reg_idx), .reg_data(reg_data), .vram_req(vram_req),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_wrdata(vram_wrdata), .vram_ack(vram_ack),
        .vram_rddata(vram_rddata), .cram_wren(cram_wren), .cram_addr(cram_addr),
        .cram_wrdata(cram_wrdata), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic we; logic [13:0] addr; logic [7:0] data; } op_t;
    op_t         ops[$];
    op_t         vlog[$];
    logic [7:0]  mem [0:16383];
    int          m_addr = 0;
    logic [1:0]  m_code = 2'd0;
    bit          m_latch = 0, m_overrun = 0;
    logic [7:0]  m_buf = 8'h00, m_rddata = 8'h00;
    bit          e_cram = 0, e_reg = 0, e_stat = 0;
    logic [4:0]  e_cram_addr = 5'h0;
    logic [15:0] e_cram_data = 16'h0;
    logic [3:0]  e_reg_idx = 4'h0;
    logic [7:0]  e_reg_data = 8'h0;

    assign vram_rddata = mem[vram_addr];

    function automatic void m_push(input bit we, input int a, input logic [7:0] d);
        op_t o;
        o.we = we; o.addr = 14'(a); o.data = d;
        if (ops.size() >= 2) m_overrun = 1;
        else ops.push_back(o);
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [7:0] old_buf;
        op_t o;
        if (reset) begin
            ops.delete();
            m_addr = 0; m_code = 0; m_latch = 0; m_overrun = 0;
            m_buf = 0; m_rddata = 0; e_cram = 0; e_reg = 0; e_stat = 0;
        end else begin
            e_cram = 0; e_reg = 0; e_stat = 0;
            old_buf = m_buf;
            if (vram_ack && ops.size() > 0) begin
                o = ops.pop_front();
                if (o.we) mem[o.addr] = o.data;
                else      m_buf = mem[o.addr];
                vlog.push_back(o);
            end
            if (io_wr && io_sel_ctrl) begin
                if (!m_latch) begin
                    m_addr  = (m_addr & 'h3F00) | int'(io_wrdata);
                    m_latch = 1;
                end else begin
                    m_addr  = (int'(io_wrdata & 8'h3F) * 256) + (m_addr % 256);
                    m_code  = io_wrdata[7:6];
                    m_latch = 0;
                    if (m_code == 0) begin
                        m_push(0, m_addr, 8'h00);
                        m_addr = (m_addr + 1) % 16384;
                    end
                    if (m_code == 2 && int'(io_wrdata % 16) < 11) begin
                        e_reg = 1; e_reg_idx = 4'(io_wrdata % 16); e_reg_data = 8'(m_addr % 256);
                    end
                end
            end else if (io_wr) begin
                m_latch = 0;
                m_buf   = io_wrdata;
                if (m_code == 3) begin
                    e_cram = 1; e_cram_addr = 5'(m_addr % 32); e_cram_data = 16'(io_wrdata % 64);
                end else begin
                    m_push(1, m_addr, io_wrdata);
                end
                m_addr = (m_addr + 1) % 16384;
            end else if (io_rd && io_sel_ctrl) begin
                m_latch = 0; m_rddata = stat_in; e_stat = 1;
            end else if (io_rd) begin
                m_latch = 0; m_rddata = old_buf;
                m_push(0, m_addr, 8'h00);
                m_addr = (m_addr + 1) % 16384;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [12:0] cram_log[$];
    logic [11:0] reg_log[$];

    always @(negedge clk) begin
        chk("io_rddata", 32'(io_rddata), 32'(m_rddata));
        chk("overrun", 32'(overrun), 32'(m_overrun));
        chk("stat_rd_ack", 32'(stat_rd_ack), 32'(e_stat));
        chk("reg_wren", 32'(reg_wren), 32'(e_reg));
        if (e_reg) begin
            chk("reg_idx", 32'(reg_idx), 32'(e_reg_idx));
            chk("reg_data", 32'(reg_data), 32'(e_reg_data));
        end
        chk("cram_wren", 32'(cram_wren), 32'(e_cram));
        if (e_cram) begin
            chk("cram_addr", 32'(cram_addr), 32'(e_cram_addr));
            chk("cram_wrdata", 32'(cram_wrdata), 32'(e_cram_data));
        end
        chk("vram_req", 32'(vram_req), 32'(ops.size() != 0));
        if (ops.size() != 0) begin
            chk("vram_we", 32'(vram_we), 32'(ops[0].we));
            chk("vram_addr", 32'(vram_addr), 32'(ops[0].addr));
            if (ops[0].we) chk("vram_wrdata", 32'(vram_wrdata), 32'(ops[0].data));
        end
        if (cram_wren) cram_log.push_back({cram_addr, cram_wrdata[7:0]});
        if (reg_wren)  reg_log.push_back({reg_idx, reg_data});
    end

    // ---------------- VRAM responder ----------------
    int ack_delay = 3;
    bit ack_hold = 0;
    int wait_cnt = 0;
    always @(negedge clk) begin
        if (vram_ack) begin
            vram_ack = 1'b0;
            wait_cnt = 0;
        end else if (vram_req && !ack_hold) begin
            if (wait_cnt >= ack_delay - 1) vram_ack = 1'b1;
            else wait_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic port_wr(input bit sel, input logic [7:0] d);
        @(negedge clk);
        io_wr = 1'b1; io_sel_ctrl = sel; io_wrdata = d;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    task automatic port_rd(input bit sel);
        @(negedge clk);
        io_rd = 1'b1; io_sel_ctrl = sel;
        @(negedge clk);
        io_rd = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        bit done = 0;
        for (int i = 0; i < max && !done; i++) begin
            @(negedge clk);
            if (!vram_req && ops.size() == 0) done = 1;
        end
        if (!done) chk("wait_idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'h5A;
        repeat (2) @(negedge clk);
        chk("rst_vram_req", 32'(vram_req), 32'd0);
        chk("rst_io_rddata", 32'(io_rddata), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_cram_wren", 32'(cram_wren), 32'd0);
        chk("rst_vram_addr", 32'(vram_addr), 32'd0);
        reset = 1'b0;

        // status read clears the latch and returns stat_in
        port_wr(1, 8'h12);
        port_rd(1);
        @(negedge clk);
        chk("stat_rddata", 32'(io_rddata), 32'hA3);

        // test 1: CRAM writes
        port_wr(1, 8'h00); port_wr(1, 8'hC0);
        for (int i = 1; i <= 7; i++) port_wr(0, 8'(i));
        repeat (2) @(negedge clk);
        chk("t1_cram_count", 32'(cram_log.size()), 32'd7);
        for (int i = 0; i < 7 && i < cram_log.size(); i++)
            chk("t1_cram_entry", 32'(cram_log[i]), 32'({5'(i), 8'(i + 1)}));
        chk("t1_no_vram", 32'(vlog.size()), 32'd0);

        // test 2: register write, then an out-of-range index that must be dropped
        port_wr(1, 8'h20); port_wr(1, 8'h81);
        repeat (2) @(negedge clk);
        chk("t2_reg_count", 32'(reg_log.size()), 32'd1);
        if (reg_log.size() > 0) chk("t2_reg_entry", 32'(reg_log[0]), 32'h120);
        chk("t2_addr_lo", 32'(m_addr % 256), 32'h20);
        port_wr(1, 8'h55); port_wr(1, 8'h8F);
        repeat (2) @(negedge clk);
        chk("t2_reg_drop", 32'(reg_log.size()), 32'd1);

        // test 3: VRAM writes
        port_wr(1, 8'h00); port_wr(1, 8'h46);
        port_wr(0, 8'hA5); wait_idle(50);
        port_wr(0, 8'hA6); wait_idle(50);
        chk("t3_vlog_n", 32'(vlog.size()), 32'd2);
        if (vlog.size() >= 2) begin
            chk("t3_w0", 32'(vlog[0]), 32'({1'b1, 14'h0600, 8'hA5}));
            chk("t3_w1", 32'(vlog[1]), 32'({1'b1, 14'h0601, 8'hA6}));
        end
        chk("t3_addr", 32'(m_addr), 32'h0602);

        // test 4: read-ahead and data reads
        port_wr(1, 8'h00); port_wr(1, 8'h06); wait_idle(50);
        port_rd(0); wait_idle(50);
        chk("t4_rd0", 32'(io_rddata), 32'hA5);
        port_rd(0); wait_idle(50);
        chk("t4_rd1", 32'(io_rddata), 32'hA6);
        chk("t4_last_ra", 32'(vlog[vlog.size() - 1]), 32'({1'b0, 14'h0602, 8'h00}));

        // test 5: data read clears the latch; address wrap
        port_wr(1, 8'h00); port_rd(0); wait_idle(50);
        port_wr(1, 8'h34); port_wr(1, 8'h7F);
        chk("t5_addr", 32'(m_addr), 32'h3F34);
        chk("t5_code", 32'(m_code), 32'd1);
        port_wr(0, 8'h44); wait_idle(50);
        chk("t5_w3f34", 32'(vlog[vlog.size() - 1]), 32'({1'b1, 14'h3F34, 8'h44}));
        port_wr(1, 8'hFF); port_wr(1, 8'h7F);
        port_wr(0, 8'h11); wait_idle(50);
        port_wr(0, 8'h22); wait_idle(50);
        chk("t5_w3fff", 32'(vlog[vlog.size() - 2]), 32'({1'b1, 14'h3FFF, 8'h11}));
        chk("t5_wrap", 32'(vlog[vlog.size() - 1]), 32'({1'b1, 14'h0000, 8'h22}));

        // test 6: starved renderer, third write dropped
        port_wr(1, 8'h00); port_wr(1, 8'h41);
        ack_hold = 1;
        port_wr(0, 8'h31); port_wr(0, 8'h32); port_wr(0, 8'h33);
        repeat (40) @(negedge clk);
        chk("t6_overrun", 32'(overrun), 32'd1);
        ack_hold = 0;
        wait_idle(100);
        chk("t6_w0", 32'(vlog[vlog.size() - 2]), 32'({1'b1, 14'h0100, 8'h31}));
        chk("t6_w1", 32'(vlog[vlog.size() - 1]), 32'({1'b1, 14'h0101, 8'h32}));
        chk("t6_sticky", 32'(overrun), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
